uriscv_alu_mc: RTL and testbench
================================

Name: uriscv_alu_mc

Overview:
- Parametrised multi-cycle ALU; the next-generation execute unit for the uriscv core.
- Generalises the single-cycle 32-bit ALU to XLEN bits.
- Registers results behind a valid/ready request/response handshake.
- Optionally adds iterative RV32M multiply/divide. Sits between decode/operand-fetch and writeback; one operation in flight at a time.

Parameters:
- XLEN, 32, datapath width; power of two, 8..64.
- MUL_STEP, 1, multiplier bits retired per iterative cycle; 1, 2 or 4, must divide XLEN. Used only with muldiv.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  unit can accept a request
- op_i  in  4  ALU op, existing `RV_ALU_* encodings
- md_i  in  1  1 = muldiv op (md_op_i) instead of op_i
- md_op_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- a_i  in  XLEN  operand A
- b_i  in  XLEN  operand B
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer accepts result
- p_o  out  XLEN  result
- busy_o  out  1  iterative op in progress

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE; req_ready_o=1, rsp_valid_o=0, p_o=0, busy_o=0.
  - All iteration counters/accumulators cleared.
- FSM states: IDLE, ITER, RESP.
  - IDLE, req_valid_i&req_ready_o:
    - ALU op (md_i=0): compute combinationally, register into p_o, go RESP. Response at cycle N+1 (latency 1).
    - Muldiv op: latch operands, go ITER.
  - ITER:
    - Multiply: XLEN/MUL_STEP cycles.
    - Divide: XLEN cycles (restoring, 1 bit/cycle).
    - Last cycle writes p_o, goes RESP. busy_o=1 only in ITER.
  - RESP: rsp_valid_o=1; p_o held stable until rsp_ready_i.
    - On handshake go IDLE.
    - Same cycle a new request may be accepted (req_ready_o=1 in RESP when rsp_ready_i=1). This gives back-to-back ALU throughput of 1/cycle.
- req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i).
- Inputs are sampled only on handshake; later changes to a_i/b_i/op_i are ignored.
- ALU op semantics at XLEN:
  - Add/sub wrap mod 2^XLEN.
  - Shifts use b_i[$clog2(XLEN)-1:0]; upper bits ignored. Arithmetic right shift fills with a_i[XLEN-1].
  - SLT/SLTU return 1 or 0 zero-extended.
  - Unknown op passes a_i through.
- Multiply:
  - Full 2*XLEN product; MUL returns the low half, MULH* the high half.
  - Operands sign-handled per RISC-V: MULHSU treats a signed, b unsigned.
- Divide:
  - Divide by zero: quotient = all ones, remainder = a_i.
  - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = a_i, remainder = 0.
  - Both special cases complete in 1 ITER cycle.
  - Remainder sign follows dividend.
- Reset mid-ITER/RESP: abort immediately and return to reset values; no response is produced.
- No request is accepted while in ITER.

Optional Feature:
- Macro URISCV_ALU_MULDIV_EN.
- Defined: muldiv datapath, ITER state and busy_o logic are compiled in.
- Undefined: ITER logic is removed and busy_o is tied 0. A request with md_i=1 completes like an ALU op with latency 1 and p_o=0 (no illegal-op signalling).

Test Plan:
- Reset then ADD a=0xFFFFFFFF b=1 -> rsp_valid_o next cycle, p_o=0x00000000. Four back-to-back ops with rsp_ready_i=1 -> 4 results in 4 consecutive cycles.
- SRA (XLEN=32) a=0x80000000 b=0x21 -> 0xC0000000 (shift amount 1). SRL same -> 0x40000000. XLEN=16 SLT a=0x8000 b=0x0001 -> 1.
- Muldiv, MUL_STEP=1: MULHU a=b=0xFFFFFFFF -> busy_o high 32 cycles, p_o=0xFFFFFFFE. MULH a=-1 b=-1 -> 0. MUL 7*-3 -> 0xFFFFFFEB.
- DIV 0x80000000/-1 -> 0x80000000; REM same -> 0; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; REM -7/2 -> 0xFFFFFFFF.
- Hold rsp_ready_i=0 for 5 cycles while changing a_i/b_i -> p_o stable, req_ready_o=0. Release -> new request accepted in the same cycle.
- Assert rst_ni low at ITER cycle 10 -> all outputs at reset values immediately. After release, a new ADD completes normally.

Source files
------------

// File: rtl/uriscv_alu_mc.sv
// uriscv_alu_mc: XLEN-wide multi-cycle ALU behind a valid/ready
// request/response handshake, one operation in flight at a time.
// Optional iterative muldiv compiled in with URISCV_ALU_MULDIV_EN.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   req_valid_i/req_ready_o  request handshake
//   op_i, md_i, md_op_i      ALU op / muldiv select / muldiv op
//   a_i, b_i                 operands
//   rsp_valid_o/rsp_ready_i  response handshake
//   p_o                      result, held until accepted
//   busy_o                   iterative op in progress

`ifndef RV_ALU_ADD
`define RV_ALU_ADD  4'd0
`endif
`ifndef RV_ALU_SUB
`define RV_ALU_SUB  4'd1
`endif
`ifndef RV_ALU_SLL
`define RV_ALU_SLL  4'd2
`endif
`ifndef RV_ALU_SLT
`define RV_ALU_SLT  4'd3
`endif
`ifndef RV_ALU_SLTU
`define RV_ALU_SLTU 4'd4
`endif
`ifndef RV_ALU_XOR
`define RV_ALU_XOR  4'd5
`endif
`ifndef RV_ALU_SRL
`define RV_ALU_SRL  4'd6
`endif
`ifndef RV_ALU_SRA
`define RV_ALU_SRA  4'd7
`endif
`ifndef RV_ALU_OR
`define RV_ALU_OR   4'd8
`endif
`ifndef RV_ALU_AND
`define RV_ALU_AND  4'd9
`endif

module uriscv_alu_mc #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_STEP = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [3:0]      op_i,
  input  logic            md_i,
  input  logic [2:0]      md_op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] p_o,
  output logic            busy_o
);

  localparam int unsigned SW      = $clog2(XLEN);
  localparam int unsigned CW      = SW + 1;
  localparam int unsigned MUL_CYC = XLEN / MUL_STEP;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] p_q, p_d;
  logic            accept;
  logic [XLEN-1:0] alu_res;
  logic [SW-1:0]   shamt;

  assign req_ready_o = (state_q == S_IDLE) |
                       ((state_q == S_RESP) & rsp_ready_i);
  assign accept      = req_valid_i & req_ready_o;
  assign rsp_valid_o = (state_q == S_RESP);
  assign p_o         = p_q;

  assign shamt = b_i[SW-1:0];

  always_comb begin
    alu_res = a_i;
    unique case (op_i)
      `RV_ALU_ADD:  alu_res = a_i + b_i;
      `RV_ALU_SUB:  alu_res = a_i - b_i;
      `RV_ALU_SLL:  alu_res = a_i << shamt;
      `RV_ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                               $signed(a_i) < $signed(b_i)};
      `RV_ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, a_i < b_i};
      `RV_ALU_XOR:  alu_res = a_i ^ b_i;
      `RV_ALU_SRL:  alu_res = a_i >> shamt;
      `RV_ALU_SRA:  alu_res = $signed(a_i) >>> shamt;
      `RV_ALU_OR:   alu_res = a_i | b_i;
      `RV_ALU_AND:  alu_res = a_i & b_i;
      default:      alu_res = a_i;
    endcase
  end

`ifdef URISCV_ALU_MULDIV_EN
  logic              md_start, md_done;
  logic [XLEN-1:0]   md_res;

  logic [2:0]        mdop_q;
  logic [CW-1:0]     cnt_q;
  // Shared iteration registers.
  // mul: acc = partial product, mcand = shifted |a|, mplier = |b|.
  // div: acc = partial remainder, mcand = |b|,
  //      mplier = dividend shifting out / quotient shifting in.
  logic [2*XLEN-1:0] acc_q, mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic              neg_q, rneg_q, spec_q;

  logic              is_div, a_sgn, b_sgn;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, spec_val;
  logic              div_zero, div_ovf, spec;

  // Both multiply and divide run on magnitudes; sign fixed at the end.
  always_comb begin
    is_div   = md_op_i[2];
    a_sgn    = is_div ? ~md_op_i[0] : (md_op_i[1:0] != 2'd3);
    b_sgn    = is_div ? ~md_op_i[0] : ~md_op_i[1];
    a_neg    = a_sgn & a_i[XLEN-1];
    b_neg    = b_sgn & b_i[XLEN-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
    div_zero = (b_i == '0);
    div_ovf  = a_sgn &&
               (a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
               (b_i == '1);
    spec     = is_div & (div_zero | div_ovf);
    if (div_zero) begin
      spec_val = md_op_i[1] ? a_i : '1;
    end else begin
      spec_val = md_op_i[1] ? '0 : a_i;
    end
  end

  logic [2*XLEN-1:0] part, acc_n, prod;
  logic [XLEN:0]     r_sh, diff;
  logic [XLEN-1:0]   rem_n, quo_n;
  logic [XLEN-1:0]   q_out, r_out;
  logic [XLEN-1:0]   mul_res, div_res;

  always_comb begin
    part = '0;
    for (int k = 0; k < int'(MUL_STEP); k++) begin
      if (mplier_q[k]) part = part + (mcand_q << k);
    end
    acc_n   = acc_q + part;
    prod    = neg_q ? -acc_n : acc_n;
    mul_res = (mdop_q[1:0] == 2'd0) ?
              prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // Restoring step; remainder never exceeds XLEN bits.
    r_sh    = {acc_q[XLEN-1:0], mplier_q[XLEN-1]};
    diff    = r_sh - {1'b0, mcand_q[XLEN-1:0]};
    rem_n   = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    quo_n   = {mplier_q[XLEN-2:0], ~diff[XLEN]};
    q_out   = neg_q ? -quo_n : quo_n;
    r_out   = rneg_q ? -rem_n : rem_n;
    div_res = mdop_q[1] ? r_out : q_out;
  end

  assign md_done = (state_q == S_ITER) &
                   (spec_q | (cnt_q == '0));
  assign md_res  = spec_q ? mplier_q :
                   (mdop_q[2] ? div_res : mul_res);
  assign busy_o  = (state_q == S_ITER);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdop_q   <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      spec_q   <= 1'b0;
    end else if (md_start) begin
      mdop_q   <= md_op_i;
      spec_q   <= spec;
      acc_q    <= '0;
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      mcand_q  <= {{XLEN{1'b0}}, is_div ? b_mag : a_mag};
      mplier_q <= spec ? spec_val :
                  (is_div ? a_mag : b_mag);
      cnt_q    <= is_div ? CW'(XLEN - 1) : CW'(MUL_CYC - 1);
    end else if (state_q == S_ITER) begin
      cnt_q <= cnt_q - CW'(1);
      if (mdop_q[2]) begin
        acc_q    <= {{XLEN{1'b0}}, rem_n};
        mplier_q <= quo_n;
      end else begin
        acc_q    <= acc_n;
        mcand_q  <= mcand_q << MUL_STEP;
        mplier_q <= mplier_q >> MUL_STEP;
      end
    end
  end
`else
  logic unused_md;
  assign unused_md = ^{md_op_i, CW'(MUL_CYC)};
  assign busy_o    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
`ifdef URISCV_ALU_MULDIV_EN
    md_start = 1'b0;
`endif
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if ((state_q == S_RESP) && rsp_ready_i) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          if (!md_i) begin
            state_d = S_RESP;
            p_d     = alu_res;
          end else begin
`ifdef URISCV_ALU_MULDIV_EN
            state_d  = S_ITER;
            md_start = 1'b1;
`else
            state_d = S_RESP;
            p_d     = '0;
`endif
          end
        end
      end
      S_ITER: begin
`ifdef URISCV_ALU_MULDIV_EN
        if (md_done) begin
          state_d = S_RESP;
          p_d     = md_res;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_uriscv_alu_mc.sv
// tb_uriscv_alu_mc: directed self-checking bench for uriscv_alu_mc
// (XLEN=32 main instance, XLEN=16 side instance).

module tb_uriscv_alu_mc;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] SLL  = 4'd2;
  localparam logic [3:0] SLT  = 4'd3;
  localparam logic [3:0] SLTU = 4'd4;
  localparam logic [3:0] XOR  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] OR   = 4'd8;
  localparam logic [3:0] AND  = 4'd9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  op;
  logic        md;
  logic [2:0]  md_op;
  logic [31:0] a, b, p;
  logic        rsp_valid, rsp_ready, busy;

  logic        v16, rdy16, rv16, busy16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, p16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uriscv_alu_mc #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .md_i(md), .md_op_i(md_op),
    .a_i(a), .b_i(b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .p_o(p), .busy_o(busy)
  );

  uriscv_alu_mc #(.XLEN(16), .MUL_STEP(1)) dut16 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v16), .req_ready_o(rdy16),
    .op_i(op16), .md_i(1'b0), .md_op_i(3'd0),
    .a_i(a16), .b_i(b16),
    .rsp_valid_o(rv16), .rsp_ready_i(1'b1),
    .p_o(p16), .busy_o(busy16)
  );

  // Present one request for one cycle; called at a negedge.
  task automatic send(input logic [3:0] o, input logic m,
                      input logic [2:0] mo,
                      input logic [31:0] x, input logic [31:0] y);
    op = o; md = m; md_op = mo; a = x; b = y;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    op = ADD; md = 1'b0; md_op = 3'd0; a = '0; b = '0;
    v16 = 1'b0; op16 = ADD; a16 = '0; b16 = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=1", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid);
    end
    checks++;
    if (p !== 32'h0) begin
      failures++;
      $display("FAIL reset_p got=%h exp=0", p);
    end
    checks++;
    if (busy !== 1'b0 || busy16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b/%b exp=0", busy, busy16);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    send(ADD, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h1);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_valid got=%b exp=1", rsp_valid);
    end
    checks++;
    if (p !== 32'h0) begin
      failures++;
      $display("FAIL add_wrap got=%h exp=00000000", p);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_idle got=%b exp=0", rsp_valid);
    end
  endtask

  logic [3:0]  bb_op[4]  = '{ADD, SUB, XOR, AND};
  logic [31:0] bb_a[4]   = '{32'h5, 32'h3, 32'hF0F0_F0F0,
                             32'h1234_5678};
  logic [31:0] bb_b[4]   = '{32'h3, 32'h5, 32'hFF00_FF00,
                             32'h0000_FFFF};
  logic [31:0] bb_exp[4] = '{32'h8, 32'hFFFF_FFFE,
                             32'h0FF0_0FF0, 32'h0000_5678};

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    md = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op = bb_op[i]; a = bb_a[i]; b = bb_b[i];
      req_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || p !== bb_exp[i]) begin
        failures++;
        $display("FAIL b2b_%0d got=%b/%h exp=1/%h",
                 i, rsp_valid, p, bb_exp[i]);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0]  sh_op[7]  = '{SRA, SRL, SLL, SLT, SLTU, OR, 4'hF};
  logic [31:0] sh_a[7]   = '{32'h8000_0000, 32'h8000_0000,
                             32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h0F, 32'hDEAD_BEEF};
  logic [31:0] sh_b[7]   = '{32'h21, 32'h21, 32'h24, 32'h1,
                             32'h1, 32'hF0, 32'h1};
  logic [31:0] sh_exp[7] = '{32'hC000_0000, 32'h4000_0000,
                             32'h10, 32'h1, 32'h0, 32'hFF,
                             32'hDEAD_BEEF};

  task automatic test_ops();
    for (int i = 0; i < 7; i++) begin
      send(sh_op[i], 1'b0, 3'd0, sh_a[i], sh_b[i]);
      checks++;
      if (rsp_valid !== 1'b1 || p !== sh_exp[i]) begin
        failures++;
        $display("FAIL op_%0d got=%b/%h exp=1/%h",
                 i, rsp_valid, p, sh_exp[i]);
      end
    end
    @(negedge clk);
  endtask

  logic [3:0]  x_op[3]  = '{SLT, SRA, ADD};
  logic [15:0] x_a[3]   = '{16'h8000, 16'h8000, 16'hFFFF};
  logic [15:0] x_b[3]   = '{16'h0001, 16'h0011, 16'h0001};
  logic [15:0] x_exp[3] = '{16'h0001, 16'hC000, 16'h0000};

  task automatic test_xlen16();
    for (int i = 0; i < 3; i++) begin
      op16 = x_op[i]; a16 = x_a[i]; b16 = x_b[i];
      v16 = 1'b1;
      @(negedge clk);
      v16 = 1'b0;
      checks++;
      if (rv16 !== 1'b1 || p16 !== x_exp[i]) begin
        failures++;
        $display("FAIL x16_%0d got=%b/%h exp=1/%h",
                 i, rv16, p16, x_exp[i]);
      end
    end
    @(negedge clk);
  endtask

`ifdef URISCV_ALU_MULDIV_EN
  logic [2:0]  m_op[11]  = '{3'd3, 3'd1, 3'd0, 3'd2, 3'd4, 3'd6,
                             3'd5, 3'd7, 3'd6, 3'd4, 3'd7};
  logic [31:0] m_a[11]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7,
                             32'hFFFF_FFFF, 32'h8000_0000,
                             32'h8000_0000, 32'h5, 32'h5,
                             32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
  logic [31:0] m_b[11]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'h0, 32'h0, 32'h2,
                             32'h2, 32'd7};
  logic [31:0] m_exp[11] = '{32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFEB,
                             32'hFFFF_FFFF, 32'h8000_0000, 32'h0,
                             32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'd2};
  int          m_cyc[11] = '{32, 32, 32, 32, 1, 1, 1, 1,
                             32, 32, 32};

  task automatic test_muldiv();
    int nb;
    rsp_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(ADD, 1'b1, m_op[i], m_a[i], m_b[i]);
      nb = 0;
      for (int c = 0; c < 100 && rsp_valid !== 1'b1; c++) begin
        if (busy === 1'b1) nb++;
        @(negedge clk);
      end
      checks++;
      if (rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL md_%0d_timeout got=%b exp=1", i, rsp_valid);
      end
      checks++;
      if (p !== m_exp[i]) begin
        failures++;
        $display("FAIL md_%0d_result got=%h exp=%h",
                 i, p, m_exp[i]);
      end
      checks++;
      if (nb != m_cyc[i]) begin
        failures++;
        $display("FAIL md_%0d_busy_cycles got=%0d exp=%0d",
                 i, nb, m_cyc[i]);
      end
    end
    @(negedge clk);
    md = 1'b0;
  endtask

  task automatic test_reset_mid_iter();
    send(ADD, 1'b1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL iter_busy got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 ||
        req_ready !== 1'b1 || p !== 32'h0) begin
      failures++;
      $display("FAIL iter_reset got=%b%b%b/%h exp=001/0",
               busy, rsp_valid, req_ready, p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    md = 1'b0;
  endtask
`else
  task automatic test_md_disabled();
    rsp_ready = 1'b1;
    send(ADD, 1'b1, 3'd0, 32'h7, 32'h3);
    checks++;
    if (rsp_valid !== 1'b1 || p !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL md_off got=%b/%h/%b exp=1/0/0",
               rsp_valid, p, busy);
    end
    md = 1'b0;
    @(negedge clk);
  endtask
`endif

  task automatic test_stall();
    rsp_ready = 1'b0;
    send(ADD, 1'b0, 3'd0, 32'h1, 32'h2);
    for (int i = 0; i < 5; i++) begin
      op = SUB; a = 32'h100 * (i + 1); b = 32'h7 + i;
      req_valid = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 ||
          p !== 32'h3) begin
        failures++;
        $display("FAIL stall_%0d got=%b%b/%h exp=01/3",
                 i, req_ready, rsp_valid, p);
      end
      @(negedge clk);
    end
    op = ADD; a = 32'd10; b = 32'd20;
    req_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release got=%b exp=1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || p !== 32'd30) begin
      failures++;
      $display("FAIL stall_next got=%b/%h exp=1/1e",
               rsp_valid, p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_resp();
    rsp_ready = 1'b0;
    send(ADD, 1'b0, 3'd0, 32'd7, 32'd8);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || p !== 32'h0 || req_ready !== 1'b1) begin
      failures++;
      $display("FAIL resp_reset got=%b/%h/%b exp=0/0/1",
               rsp_valid, p, req_ready);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_after_reset();
    send(ADD, 1'b0, 3'd0, 32'd2, 32'd2);
    checks++;
    if (rsp_valid !== 1'b1 || p !== 32'd4) begin
      failures++;
      $display("FAIL post_reset_add got=%b/%h exp=1/4",
               rsp_valid, p);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_ops();
    test_xlen16();
`ifdef URISCV_ALU_MULDIV_EN
    test_muldiv();
`else
    test_md_disabled();
`endif
    test_stall();
`ifdef URISCV_ALU_MULDIV_EN
    test_reset_mid_iter();
`endif
    test_reset_mid_resp();
    test_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
